// File: rtl/inst_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch_queue
//  Description : Instruction fetch front-end. Holds the fetch PC, issues
//                sequential reads to instruction memory, buffers returned
//                words with their PC in a prefetch FIFO and presents the
//                head to decode. Supports jump redirect/flush and
//                end-of-program halt.
//                Optional macro FETCH_PERF_CNT_EN adds the perf_stall and
//                perf_flush saturating counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_queue #(
    parameter int         DEPTH    = 4,
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter logic [3:0] EOP_OPC  = 4'hF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_rvalid,
    input  logic        jmp,
    input  logic [7:0]  jmp_tgt,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [15:0] inst_in,
    output logic [7:0]  pc_out,
    output logic        eop,
    output logic        halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0] perf_stall,
    output logic [15:0] perf_flush
`endif
);

    localparam int              c_AW       = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_DEPTH    = (c_AW+1)'(DEPTH);
    localparam logic [c_AW:0]   c_CNT_ONE  = (c_AW+1)'(1);
    localparam logic [c_AW-1:0] c_PTR_ONE  = c_AW'(1);
    localparam logic [0:0]      c_ST_RUN   = 1'b0;
    localparam logic [0:0]      c_ST_HALT  = 1'b1;

    logic [0:0]      r_state;
    logic            r_run_en;       // low for the first cycle after reset release
    logic [7:0]      r_fetch_pc;
    logic [7:0]      r_issued_pc;    // PC of the read whose data returns this cycle
    logic            r_outstanding;
    logic [23:0]     r_mem [DEPTH];  // {inst[15:0], pc[7:0]}
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW:0]   r_count;

    logic            w_push;
    logic            w_pop;
    logic            w_eop_push;
    logic            w_room;
    logic [23:0]     w_head;

    // Return data only counts if a read was really outstanding; a jump in the
    // same cycle discards it (this also covers stray rvalid right after reset).
    assign w_push     = imem_rvalid && r_outstanding && !jmp;
    assign w_eop_push = w_push && (imem_rdata[15:12] == EOP_OPC);
    assign w_pop      = inst_valid && inst_ready;
    assign w_room     = ({1'b0, r_count} + {{(c_AW+1){1'b0}}, r_outstanding}) < {1'b0, c_DEPTH};
    assign w_head     = r_mem[r_rd_ptr];

    // The EOP word blocks the request in its own arrival cycle so nothing
    // behind it is ever fetched.
    assign imem_req   = r_run_en && (r_state == c_ST_RUN) && !jmp && w_room && !w_eop_push;
    assign imem_addr  = r_fetch_pc;
    assign inst_valid = (r_count != '0);
    assign inst_in    = inst_valid ? w_head[23:8] : 16'h0000;
    assign pc_out     = inst_valid ? w_head[7:0]  : 8'h00;
    assign eop        = w_pop && (w_head[23:20] == EOP_OPC);
    assign halted     = (r_state == c_ST_HALT);

    // FIFO storage: data needs no reset since the head is gated by inst_valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {imem_rdata, r_issued_pc};
        end
    end

    // Fetch PC, in-flight tracking, FIFO pointers and run/halt state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_ST_RUN;
            r_run_en      <= 1'b0;
            r_fetch_pc    <= RESET_PC;
            r_issued_pc   <= RESET_PC;
            r_outstanding <= 1'b0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
        end else begin
            r_run_en      <= 1'b1;
            r_outstanding <= imem_req;
            if (jmp) begin
                r_state    <= c_ST_RUN;
                r_fetch_pc <= jmp_tgt;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_count    <= '0;
            end else begin
                if (imem_req) begin
                    r_fetch_pc  <= r_fetch_pc + 8'd1;
                    r_issued_pc <= r_fetch_pc;
                end
                if (w_eop_push) begin
                    r_state <= c_ST_HALT;
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                end
                unique case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + c_CNT_ONE;
                    2'b01:   r_count <= r_count - c_CNT_ONE;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Saturating counters for decode stall cycles and redirect events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall <= 16'h0000;
            perf_flush <= 16'h0000;
        end else begin
            if (inst_valid && !inst_ready && (perf_stall != 16'hFFFF)) begin
                perf_stall <= perf_stall + 16'd1;
            end
            if (jmp && (perf_flush != 16'hFFFF)) begin
                perf_flush <= perf_flush + 16'd1;
            end
        end
    end
`endif

    // The issue throttle reserves a slot for every read in flight, so an
    // enqueue into a full FIFO can never happen.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && (r_count == c_DEPTH)));

endmodule
`default_nettype wire
